// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
// The master side issues start/op/operands/flush; the slave answers busy/done/result.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [4:0]      rd_in;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, op, src1, src2, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, op, src1, src2, rd_in, flush,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M mul/div: 32 CALC cycles then a one-cycle done pulse (special cases finish in one edge).
// busy stalls the pipeline from issue through CALC; start is ignored outside IDLE, flush kills in-flight work.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_muldiv_unit_if.slave io
);
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state;
  logic [4:0]        r_cnt;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic              r_neg_main;
  logic              r_neg_rem;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  logic            w_is_div;
  logic            w_s1;
  logic            w_s2;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_accept;

  assign w_is_div = io.op[2];
  // Signed divide ops have op[0]=0; signed multiplies are MULH (both) and MULHSU (src1 only).
  assign w_s1 = io.src1[XLEN-1] &
                (w_is_div ? ~io.op[0] : (io.op == OP_MULH || io.op == OP_MULHSU));
  assign w_s2 = io.src2[XLEN-1] & (w_is_div ? ~io.op[0] : (io.op == OP_MULH));
  assign w_mag1 = w_s1 ? -io.src1 : io.src1;
  assign w_mag2 = w_s2 ? -io.src2 : io.src2;

  assign w_div0    = w_is_div && (io.src2 == '0);
  assign w_ovf     = w_is_div && !io.op[0] &&
                     (io.src1 == {1'b1, {(XLEN-1){1'b0}}}) && (io.src2 == '1);
  assign w_special = w_div0 | w_ovf;
  // Overflow DIV returns the dividend itself (0x80000000), overflow REM returns 0.
  assign w_special_res = w_div0 ? (io.op[1] ? io.src1 : '1)
                                : (io.op[1] ? '0 : io.src1);

  assign w_accept = (r_state == S_IDLE) && io.start && !io.flush;
  assign io.busy  = (w_accept && !w_special) || (r_state == S_CALC);

  // Multiply: {hi, multiplier} shifts right, adding the multiplicand into hi on a set LSB.
  // Divide: {remainder, dividend/quotient} shifts left, restoring on a failed trial subtract.
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_div_trial;
  logic [2*XLEN-1:0] w_mul_next;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_acc_next;

  assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_rem_sh    = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_trial = w_rem_sh - {1'b0, r_b};
  assign w_div_next  = w_div_trial[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                         : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_acc_next  = r_op[2] ? w_div_next : w_mul_next;

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_prod = r_neg_main ? -w_acc_next : w_acc_next;
  assign w_quo  = w_acc_next[XLEN-1:0];
  assign w_rem  = w_acc_next[2*XLEN-1:XLEN];
  assign w_final = !r_op[2] ? ((r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN])
                 : r_op[1]  ? (r_neg_rem ? -w_rem : w_rem)
                            : (r_neg_main ? -w_quo : w_quo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_rd       <= '0;
      r_acc      <= '0;
      r_b        <= '0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_rd_out   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= io.op;
            r_rd       <= io.rd_in;
            r_acc      <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
            r_b        <= w_is_div ? w_mag2 : w_mag1;
            r_neg_main <= w_s1 ^ w_s2;
            r_neg_rem  <= w_s1;
            r_cnt      <= '0;
            if (w_special) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_special_res;
              r_rd_out <= io.rd_in;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (io.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_final;
              r_rd_out <= r_rd;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io.done   = r_done;
  assign io.result = r_result;
  assign io.rd_out = r_rd_out;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed RV32M vectors, randomized ops against an arithmetic
// reference model, flush, flush-with-start and asynchronous reset during an operation.
module tb_ex_muldiv_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ex_muldiv_unit_if #(.XLEN(32)) mif ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
    logic        busy_issue;
    logic        busy_gap;
    logic        busy_done;
    logic        pulse_one;
    logic        held;
  } obs_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        special;
  } vec_t;

  vec_t dir_v[14];

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero like RV32M.
  function automatic logic [31:0] ref_muldiv(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          ub_s;
    longint          p;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned up;
    sa   = $signed(a);
    sb   = $signed(b);
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    ub_s = ub;
    case (op)
      3'd0: begin up = ua * ub;  return up[31:0];  end
      3'd1: begin p = sa * sb;   return p[63:32];  end
      3'd2: begin p = sa * ub_s; return p[63:32];  end
      3'd3: begin up = ua * ub;  return up[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; up = ua / ub; return up[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; up = ua % ub; return up[31:0]; end
    endcase
  endfunction

  // Issues one op holding start with stable operands while busy, and records what is observed.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output obs_t o);
    logic seen;
    o.res = 'x; o.rd = 'x; o.lat = 0;
    o.busy_gap = 1'b0; o.busy_done = 1'bx; o.pulse_one = 1'b0; o.held = 1'b0;
    @(negedge clk);
    mif.start = 1'b1; mif.op = op; mif.src1 = a; mif.src2 = b; mif.rd_in = rd; mif.flush = 1'b0;
    #1;
    o.busy_issue = mif.busy;
    seen = 1'b0;
    while (!seen && o.lat < 50) begin
      @(posedge clk);
      #1;
      o.lat++;
      if (mif.done) begin
        seen        = 1'b1;
        o.res       = mif.result;
        o.rd        = mif.rd_out;
        o.busy_done = mif.busy;
      end else if (!mif.busy) begin
        o.busy_gap = 1'b1;
      end
    end
    mif.start = 1'b0;
    @(posedge clk);
    #1;
    o.pulse_one = !mif.done;
    o.held      = (mif.result === o.res) && (mif.rd_out === o.rd);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mif.start = 1'b0; mif.flush = 1'b0; mif.op = '0;
    mif.src1 = '0; mif.src2 = '0; mif.rd_in = '0;
    #2;
    checks++; if (mif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", mif.done); end
    checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", mif.busy); end
    checks++; if (mif.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", mif.result); end
    checks++; if (mif.rd_out !== 5'h0) begin errors++; $display("FAIL reset_rd_out: got %h want 0", mif.rd_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    obs_t o;
    int   want_lat;
    dir_v[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    dir_v[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    dir_v[2]  = '{3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    dir_v[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    dir_v[4]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
    dir_v[5]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
    dir_v[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       1'b0};
    dir_v[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        1'b0};
    dir_v[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
    dir_v[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        1'b1};
    dir_v[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    dir_v[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    dir_v[12] = '{3'd4, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b1};
    dir_v[13] = '{3'd7, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b1};
    for (int i = 0; i < 14; i++) begin
      run_op(dir_v[i].op, dir_v[i].a, dir_v[i].b, 5'(i + 1), o);
      want_lat = dir_v[i].special ? 1 : 33;
      checks++; if (o.res !== dir_v[i].exp) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, o.res, dir_v[i].exp); end
      checks++; if (o.rd !== 5'(i + 1)) begin errors++; $display("FAIL dir%0d_rd_out: got %0d want %0d", i, o.rd, i + 1); end
      checks++; if (o.lat != want_lat) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, o.lat, want_lat); end
      checks++; if (o.busy_issue !== !dir_v[i].special) begin errors++; $display("FAIL dir%0d_busy_issue: got %b want %b", i, o.busy_issue, !dir_v[i].special); end
      checks++; if (o.busy_gap !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_calc: got gap %b want 0", i, o.busy_gap); end
      checks++; if (o.busy_done !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_done: got %b want 0", i, o.busy_done); end
      checks++; if (o.pulse_one !== 1'b1) begin errors++; $display("FAIL dir%0d_done_width: got extra cycle, want single pulse", i); end
      checks++; if (o.held !== 1'b1) begin errors++; $display("FAIL dir%0d_hold: result/rd_out changed after done, want held", i); end
    end
  endtask

  task automatic test_random();
    obs_t        o;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [4:0]  rd;
    logic        special;
    int          mode;
    for (int i = 0; i < 80; i++) begin
      op   = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 5);
      a    = $urandom;
      b    = $urandom;
      rd   = 5'($urandom_range(0, 31));
      case (mode)
        1: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
        2: b = 32'h0;
        3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        4: begin
          a = ($urandom_range(0, 1) != 0) ? 32'h7FFFFFFF : 32'h80000000;
          b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h00000001;
        end
        default: ;
      endcase
      exp     = ref_muldiv(op, a, b);
      special = op[2] && ((b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
      run_op(op, a, b, rd, o);
      checks++; if (o.res !== exp) begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h", i, op, a, b, o.res, exp); end
      checks++; if (o.rd !== rd) begin errors++; $display("FAIL rnd%0d_rd_out: got %0d want %0d", i, o.rd, rd); end
      checks++; if (o.lat != (special ? 1 : 33)) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, o.lat, special ? 1 : 33); end
      checks++; if (o.busy_issue !== !special) begin errors++; $display("FAIL rnd%0d_busy_issue: got %b want %b", i, o.busy_issue, !special); end
      checks++; if (o.pulse_one !== 1'b1) begin errors++; $display("FAIL rnd%0d_done_width: got extra cycle, want single pulse", i); end
    end
  endtask

  task automatic test_flush();
    obs_t o;
    int   seen;
    @(negedge clk);
    mif.start = 1'b1; mif.op = 3'd0; mif.src1 = $urandom; mif.src2 = $urandom;
    mif.rd_in = 5'd9; mif.flush = 1'b0;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    mif.flush = 1'b1;
    #1;
    checks++; if (mif.busy !== 1'b1) begin errors++; $display("FAIL flush_busy_in_calc: got %b want 1", mif.busy); end
    @(posedge clk);
    #1;
    mif.flush = 1'b0;
    mif.start = 1'b0;
    #1;
    checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b want 0", mif.busy); end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (mif.done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_done: got %0d done pulses want 0", seen); end
    run_op(3'd0, 32'd3, 32'd4, 5'd12, o);
    checks++; if (o.res !== 32'd12) begin errors++; $display("FAIL flush_next_result: got %h want %h", o.res, 32'd12); end
    checks++; if (o.rd !== 5'd12) begin errors++; $display("FAIL flush_next_rd_out: got %0d want 12", o.rd); end
    checks++; if (o.lat != 33) begin errors++; $display("FAIL flush_next_latency: got %0d want 33", o.lat); end
  endtask

  task automatic test_flush_with_start();
    int seen;
    @(negedge clk);
    mif.start = 1'b1; mif.flush = 1'b1; mif.op = 3'd5; mif.src1 = 32'd5; mif.src2 = 32'd0; mif.rd_in = 5'd3;
    #1;
    checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL flush_start_special_busy: got %b want 0", mif.busy); end
    @(negedge clk);
    mif.op = 3'd0; mif.src1 = 32'd6; mif.src2 = 32'd7;
    #1;
    checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b want 0", mif.busy); end
    @(negedge clk);
    mif.start = 1'b0; mif.flush = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (mif.done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_start_no_done: got %0d done pulses want 0", seen); end
    checks++; if (mif.result !== 32'd12) begin errors++; $display("FAIL flush_start_result_held: got %h want %h", mif.result, 32'd12); end
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    @(negedge clk);
    mif.start = 1'b1; mif.op = 3'd4; mif.src1 = 32'h12345678; mif.src2 = 32'd77;
    mif.rd_in = 5'd17; mif.flush = 1'b0;
    repeat (16) @(posedge clk);
    #3;
    rst_n = 1'b0;
    mif.start = 1'b0;
    #1;
    checks++; if (mif.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", mif.done); end
    checks++; if (mif.result !== 32'h0) begin errors++; $display("FAIL rst_mid_result: got %h want 0", mif.result); end
    checks++; if (mif.rd_out !== 5'h0) begin errors++; $display("FAIL rst_mid_rd_out: got %h want 0", mif.rd_out); end
    checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", mif.busy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (mif.done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d done pulses want 0", seen); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_flush_with_start();
    test_reset_mid_calc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage. It consumes the two forwarded ALU operands (`ALU_in1`, `ALU_in2`) and, over 32 iteration cycles, produces a 32-bit product half, quotient or remainder. It stalls the front of the pipeline through a busy signal and returns its result, with the destination register, to the EX/MEM register on a one-cycle `done` pulse.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  the M-extension instruction in EX is valid and requests execution.
- `op`  in  3  funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU;
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src1`  in  XLEN  forwarded operand 1 (`ALU_in1`).
- `src2`  in  XLEN  forwarded operand 2 (`ALU_in2`).
- `rd_in`  in  5  destination register of the instruction.
- `flush`  in  1  kill any operation in flight (branch mispredict or exception).
- `busy`  out  1  stall request to the hazard unit.
- `done`  out  1  one-cycle pulse; `result` and `rd_out` are valid.
- `result`  out  XLEN  final value.
- `rd_out`  out  5  latched `rd_in`.

## Operation
- **States:**
  - IDLE: wait for a request.
  - CALC: iterate.
  - DONE: present the result.
- **Accept:** in IDLE with `start`=1 and `flush`=0, the unit latches `op` and `rd_in`. It also latches the operand magnitudes and the sign flags:
  - MULH: both operands signed.
  - MULHSU: `src1` signed.
  - DIV/REM: both operands signed.
  - All others: unsigned.
- **Multiply:** unsigned shift-add, one multiplier bit per cycle, 64-bit accumulator. The product is negated when the operand signs differ.
  - MUL returns bits [31:0].
  - MULH, MULHSU and MULHU return bits [63:32].
- **Divide:** restoring, one quotient bit per cycle.
  - Quotient sign = sign1 XOR sign2.
  - Remainder takes the sign of the dividend.
- **Special cases:** these skip CALC and go IDLE→DONE in one edge.
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `src1`.
  - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM with the same operands returns 0.
- **Transitions:**
  - IDLE→CALC on an accepted start with no special case; the 5-bit counter is cleared.
  - CALC→DONE when the counter reaches 31.
  - DONE→IDLE unconditionally.
  - Any state→IDLE on `flush`. `done` is never raised for a flushed operation.
- **`busy`** is combinational:
  - 1 in IDLE when `start`=1, `flush`=0 and no special case applies.
  - 1 throughout CALC.
  - 0 in DONE, so the pipeline advances in the same cycle that `result` is captured.
- **`start` outside IDLE** is ignored. The hazard unit guarantees it is held with stable operands while `busy`=1.
- **Reset values:** state=IDLE, `busy`=0 (given `start`=0), `done`=0, `result`=0, `rd_out`=0, counter=0.

## Timing
- Normal operation, with start accepted at edge E:
  - CALC spans cycles E..E+31.
  - DONE is entered at edge E+32; `done`=1 for exactly that cycle.
  - The unit is back in IDLE at E+33. Total stall is 33 cycles including the issue cycle.
- Special-case latency: DONE at edge E, `done` high for one cycle, `busy` never asserted.
- `result` and `rd_out` hold their values after DONE until the next DONE.
- Simultaneous events:
  - `flush` in DONE: `done` is still asserted, because that instruction has already retired from EX.
  - `flush`=1 together with `start` in IDLE: the request is not accepted.
- Reset asserted mid-CALC: all outputs clear immediately (asynchronous). After `rst_n` rises, no `done` appears for the aborted operation.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → after 32 CALC cycles, `done` pulses once with `result`=0xFFFFFFEB and `rd_out`=`rd_in`.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU with the same operands → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- REM 0xFFFFFFF9 (−7) , 2 → 0xFFFFFFFF; DIV with the same operands → 0xFFFFFFFD; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Special cases → `done` one cycle after the start edge and `busy` never high:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- `flush` raised at CALC cycle 10 → IDLE next edge, no `done`. A new MUL 3 × 4 issued immediately after completes with 12.
- `rst_n` pulsed low mid-DIV → `done`, `result` and `rd_out` are 0 at once; no `done` after release.
